// File: rtl/spi_regfile_periph.sv
// SPI mode-0 slave with a parametrised register file, fully in the iclk domain.
// Define SPI_AUTOINC_EN for burst accesses with address auto-increment and wrap to 0.
module spi_regfile_periph #(
    parameter int          NUM_REGS    = 60,
    parameter int          NUM_WR_REGS = 3,
    parameter int          ADDR_W      = 7,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CHIP_ID     = 8'hC5,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                                   i_iclk,
    input  logic                                   i_rst,
    input  logic                                   i_sclk,
    input  logic                                   i_cs_n,
    input  logic                                   i_serial_in,
    output logic                                   o_serial_out,
    input  logic [8*(NUM_REGS-1-NUM_WR_REGS)-1:0]  i_ro_regs,
    output logic [8*NUM_WR_REGS-1:0]               o_wr_regs,
    output logic [NUM_WR_REGS-1:0]                 o_wr_strobe,
    output logic                                   o_busy
);
    localparam int NUM_RO = NUM_REGS - 1 - NUM_WR_REGS;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_ABORT} state_t;
    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx, r_wr_byte, r_tx, w_rd_data;
    logic [ADDR_W-1:0]      r_addr;
    logic [31:0]            w_addr_ext;
    logic                   r_is_wr, r_cmd_done, r_byte_done, r_load, r_fall_d;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   w_sclk_s, w_cs_s, w_mosi_s;
    logic                   w_rise, w_fall, w_cs_fall, w_cs_rise, w_active, w_timeout;

    // Synchronisers and edge history are left unreset so a frame in flight at reset is not mistaken for a new one.
    always_ff @(posedge i_iclk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_serial_in};
        r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk_s & ~r_sclk_prev;
    assign w_fall     = ~w_sclk_s & r_sclk_prev;
    assign w_cs_fall  = r_cs_prev & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_prev & w_cs_s;
    assign w_active   = (r_state == S_CMD) || (r_state == S_DATA);
    assign w_timeout  = w_active && (r_bit_cnt != 3'd0) && (r_to_cnt == '0);
    assign w_addr_ext = 32'(r_addr);

    always_ff @(posedge i_iclk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_next = S_CMD;
            S_CMD:   if (w_cs_rise) w_next = S_IDLE;
                     else if (w_timeout) w_next = S_ABORT;
                     else if (w_rise && r_bit_cnt == 3'd7) w_next = S_DATA;
            S_DATA:  if (w_cs_rise) w_next = S_IDLE;
                     else if (w_timeout) w_next = S_ABORT;
            S_ABORT: if (w_cs_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (w_addr_ext == 32'd0) w_rd_data = CHIP_ID;
        for (int j = 0; j < NUM_WR_REGS; j++)
            if (w_addr_ext == 32'(j + 1)) w_rd_data = o_wr_regs[8*j +: 8];
        for (int k = 0; k < NUM_RO; k++)
            if (w_addr_ext == 32'(NUM_WR_REGS + 1 + k)) w_rd_data = i_ro_regs[8*k +: 8];
    end

    always_ff @(posedge i_iclk) begin
        if (i_rst) begin
            r_bit_cnt <= '0;  r_rx <= '0;  r_wr_byte <= '0;  r_tx <= '0;
            r_addr <= '0;  r_is_wr <= 1'b0;  r_cmd_done <= 1'b0;  r_byte_done <= 1'b0;
            r_load <= 1'b0;  r_fall_d <= 1'b0;  r_to_cnt <= '0;
            o_wr_regs <= '0;  o_wr_strobe <= '0;  o_serial_out <= 1'b0;
        end else begin
            r_cmd_done  <= 1'b0;
            r_byte_done <= 1'b0;
            r_load      <= r_cmd_done | r_byte_done;
            r_fall_d    <= w_fall;
            o_wr_strobe <= '0;

            if (r_state == S_IDLE && w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_active && w_rise && !w_timeout) begin
                r_rx      <= {r_rx[6:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    if (r_state == S_CMD) begin
                        r_is_wr    <= r_rx[6];
                        r_addr     <= {r_rx[ADDR_W-2:0], w_mosi_s};
                        r_cmd_done <= 1'b1;
                    end else begin
                        r_wr_byte   <= {r_rx[6:0], w_mosi_s};
                        r_byte_done <= 1'b1;
                    end
                end
            end

            // Down-counter reloads on every sclk edge and whenever we sit on a byte boundary.
            if (!w_active || r_bit_cnt == 3'd0 || w_rise || w_fall)
                r_to_cnt <= TO_W'(TIMEOUT_CYC - 1);
            else if (r_to_cnt != '0)
                r_to_cnt <= r_to_cnt - TO_W'(1);

            // Commit is independent of state so a byte finishing alongside cs_n rising still lands.
            if (r_byte_done) begin
                if (r_is_wr) begin
                    for (int j = 0; j < NUM_WR_REGS; j++) begin
                        if (w_addr_ext == 32'(j + 1)) begin
                            o_wr_regs[8*j +: 8] <= r_wr_byte;
                            o_wr_strobe[j]      <= 1'b1;
                        end
                    end
                end
`ifdef SPI_AUTOINC_EN
                if (w_addr_ext >= 32'(NUM_REGS - 1)) r_addr <= '0;
                else                                 r_addr <= r_addr + ADDR_W'(1);
`else
                r_addr <= r_addr;
`endif
            end

            if (r_state == S_DATA && !r_is_wr) begin
                if (r_fall_d) begin
                    o_serial_out <= r_tx[7];
                    r_tx         <= {r_tx[6:0], 1'b0};
                end
            end else begin
                o_serial_out <= 1'b0;
            end

            if (r_load) r_tx <= w_rd_data;
        end
    end
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph; expectations follow SPI_AUTOINC_EN when defined.
module tb_spi_regfile_periph;
    localparam int HALF = 8;
    localparam int TO   = 1024;

    logic         iclk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic         miso, busy;
    logic [447:0] ro_regs = '0;
    logic [23:0]  wr_regs;
    logic [2:0]   wr_strobe;

    int checks = 0, errors = 0;
    int strobe_cnt [3] = '{default: 0};
    int snap_cnt   [3] = '{default: 0};
    logic [7:0]   rx, rx2;
    logic [31:0]  exp_regs;

    spi_regfile_periph dut (
        .i_iclk(iclk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_serial_in(mosi),
        .o_serial_out(miso), .i_ro_regs(ro_regs), .o_wr_regs(wr_regs),
        .o_wr_strobe(wr_strobe), .o_busy(busy)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk)
        for (int j = 0; j < 3; j++)
            if (wr_strobe[j]) strobe_cnt[j] <= strobe_cnt[j] + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic snap();
        for (int j = 0; j < 3; j++) snap_cnt[j] = strobe_cnt[j];
    endtask

    task automatic check_strobes(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_s0"}, 32'(strobe_cnt[0] - snap_cnt[0]), 32'(e0));
        check({tag, "_s1"}, 32'(strobe_cnt[1] - snap_cnt[1]), 32'(e1));
        check({tag, "_s2"}, 32'(strobe_cnt[2] - snap_cnt[2]), 32'(e2));
    endtask

    task automatic spi_bit(input logic b, output logic rb);
        mosi = b;
        wait_clk(HALF);
        rb   = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rxb[i] = b;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    initial begin
        logic b;
        ro_regs[7:0]       = 8'h3C;
        ro_regs[8*55 +: 8] = 8'hA7;

        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        check("rst_wr_regs", 32'(wr_regs), 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // single write to address 2
        snap();
        cs_low();
        check("busy_in_frame", 32'(busy), 32'h1);
        spi_byte(8'h82, rx);
        spi_byte(8'h5A, rx);
        cs_high();
        check("wr2_regs", 32'(wr_regs), 32'h005A00);
        check_strobes("wr2", 0, 1, 0);
        check("wr2_busy_after", 32'(busy), 32'h0);

        cs_low();
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check("rd_chip_id", 32'(rx), 32'hC5);

        cs_low();
        spi_byte(8'h04, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check("rd_ro0", 32'(rx), 32'h3C);

        // burst write starting at address 1
        snap();
        cs_low();
        spi_byte(8'h81, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_byte(8'h33, rx);
        spi_byte(8'h44, rx);
        cs_high();
`ifdef SPI_AUTOINC_EN
        exp_regs = 32'h332211;
        check_strobes("burst", 1, 1, 1);
`else
        exp_regs = 32'h005A44;
        check_strobes("burst", 4, 0, 0);
`endif
        check("burst_regs", 32'(wr_regs), exp_regs);

        // two-byte read from the last address
        cs_low();
        spi_byte(8'h3B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx2);
        cs_high();
        check("rd59_b0", 32'(rx), 32'hA7);
`ifdef SPI_AUTOINC_EN
        check("rd59_b1", 32'(rx2), 32'hC5);
`else
        check("rd59_b1", 32'(rx2), 32'hA7);
`endif

        cs_low();
        spi_byte(8'h01, rx);
        spi_byte(8'h00, rx);
        cs_high();
`ifdef SPI_AUTOINC_EN
        check("rd_addr1", 32'(rx), 32'h11);
`else
        check("rd_addr1", 32'(rx), 32'h44);
`endif

        // stall mid-byte long enough to abort, then keep clocking
        cs_low();
        spi_byte(8'h81, rx);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        wait_clk(TO + 20);
        check("abort_busy", 32'(busy), 32'h1);
        snap();
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        spi_byte(8'hFF, rx);
        check("abort_no_write", 32'(wr_regs), exp_regs);
        check_strobes("abort", 0, 0, 0);
        check("abort_miso", 32'(miso), 32'h0);
        cs_high();
        check("abort_idle_busy", 32'(busy), 32'h0);

        // reset in the middle of a data byte
        cs_low();
        spi_byte(8'h82, rx);
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("midrst_wr_regs", 32'(wr_regs), 32'h0);
        check("midrst_strobe", 32'(wr_strobe), 32'h0);
        check("midrst_miso", 32'(miso), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        snap();
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        cs_high();
        check("midrst_tail_ignored", 32'(wr_regs), 32'h0);

        snap();
        cs_low();
        spi_byte(8'h83, rx);
        spi_byte(8'h9C, rx);
        cs_high();
        check("post_rst_regs", 32'(wr_regs), 32'h9C0000);
        check_strobes("post_rst", 0, 0, 1);

        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check("rd_addr3", 32'(rx), 32'h9C);

        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check("rd_addr2", 32'(rx), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
